rs232_rx_ctrl: RTL and testbench
================================

Name: rs232_rx_ctrl

Overview:
- Controller between the RS232 byte receiver (rdy/data/done handshake) and the processor I/O bus.
- Acknowledges each received byte with a one-cycle done pulse and buffers bytes in a DEPTH-entry FIFO.
- Exposes avail/count/overrun status and a pop-on-read data port, so software no longer has to service every byte within one character time.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- AW, 4, pointer width; must equal log2(DEPTH).
- RTS_MARGIN, 4, free entries below which rts deasserts (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_rdy  in  1  receiver "byte available" (level).
- rx_data  in  8  receiver byte, valid while rx_rdy=1.
- rx_done  out  1  one-cycle acknowledge to the receiver's done input.
- rd  in  1  processor read strobe for the data register; pops one byte.
- rd_data  out  8  FIFO head byte; valid while avail=1.
- avail  out  1  FIFO non-empty.
- count  out  AW+1  bytes held, 0..DEPTH.
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- clr_ovr  in  1  clears overrun.
- rts  out  1  flow control; present only with RS232_RX_RTS_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM→IDLE; wr/rd pointers=0; count=0; rx_done=0; overrun=0; rts=1.
  - avail=0; rd_data is don't-care.
- FSM, all transitions registered:
  - IDLE: if rx_rdy=1, capture rx_data (push or drop), go to ACK.
  - ACK: rx_done=1 for exactly this one cycle; go to WAIT.
  - WAIT: stay until rx_rdy=0, then go to IDLE. This guarantees one push per received byte regardless of how long the receiver takes to clear rdy.
- rx_done is a registered output and is 1 only in ACK.
- Push, on the IDLE-with-rx_rdy cycle:
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is discarded and overrun is set at the next edge.
- Pop: rd=1 with avail=1 advances the read pointer. rd=1 with avail=0 is ignored: no state change, no underflow.
- rd_data: combinational read of mem[rptr]. First-word-fall-through: a pushed byte is visible the cycle after the push edge.
- count:
  - +1 on push only; −1 on pop only; unchanged on simultaneous push and pop.
  - Pointers wrap modulo DEPTH.
  - avail = (count≠0).
- overrun:
  - Set on a dropped push.
  - Cleared by clr_ovr=1.
  - If set and clear occur in the same cycle, set wins.
- Latency: rx_rdy rise → rx_done 1 cycle later (ACK) → avail 1 cycle after capture.
- Reset mid-handshake: the FSM returns to IDLE and the FIFO is emptied. If the receiver still holds rx_rdy after reset release, that byte is captured and acknowledged normally.

Optional Feature:
- RS232_RX_RTS_EN defined:
  - Port rts exists and is registered.
  - rts=1 when (DEPTH−count) > RTS_MARGIN, else 0. Recomputed every cycle from next-state count.
- Undefined: port rts and its logic are absent; no other behaviour changes.

Decomposition:
- Package rs232_pkg holds:
  - the FSM state enum (IDLE, ACK, WAIT), 2 bits;
  - constant BYTE_W=8;
  - default DEPTH.
- One sub-module, rs232_rx_fifo: synchronous FIFO with push/pop/count/head output and simultaneous push+pop when full.
- rs232_rx_ctrl holds the FSM, the overrun logic and rts.

Test Plan:
- Single byte: rx_rdy=1 with 0x5A, held 3 cycles → rx_done high exactly 1 cycle, 1 cycle after the rise; avail=1, count=1, rd_data=0x5A; rd pulse → avail=0, count=0.
- Burst fill: 17 bytes 0x00..0x10, no reads (DEPTH=16) → count=16, overrun=1; reads return 0x00..0x0F in order; 0x10 is never returned.
- Full with simultaneous pop: FIFO full, next byte 0xA5 arrives in the same cycle as rd → push accepted, count stays 16, overrun stays 0; 0xA5 is read last.
- Overrun clear race: dropped push and clr_ovr=1 in the same cycle → overrun=1; clr_ovr alone the next cycle → overrun=0.
- Long rx_rdy: rx_rdy held 20 cycles for one byte → exactly one push and one rx_done pulse.
- Reset mid-handshake, plus rts (with RS232_RX_RTS_EN, RTS_MARGIN=4):
  - rst during ACK with count=5 → next cycle rx_done=0, count=0, avail=0.
  - Fill to 12 → rts=0; one read → rts=1.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 receive controller.
package rs232_pkg;
    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rx_state_e;
endpackage

// File: rtl/rs232_rx_ctrl_if.sv
// Receiver handshake plus processor-side status/data bundle; rts exists only with RS232_RX_RTS_EN.
interface rs232_rx_ctrl_if import rs232_pkg::*; #(parameter int AW = 4);
    logic              rx_rdy;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_done;
    logic              rd;
    logic [BYTE_W-1:0] rd_data;
    logic              avail;
    logic [AW:0]       count;
    logic              overrun;
    logic              clr_ovr;
`ifdef RS232_RX_RTS_EN
    logic              rts;

    modport master (output rx_rdy, rx_data, rd, clr_ovr,
                    input  rx_done, rd_data, avail, count, overrun, rts);
    modport slave  (input  rx_rdy, rx_data, rd, clr_ovr,
                    output rx_done, rd_data, avail, count, overrun, rts);
`else
    modport master (output rx_rdy, rx_data, rd, clr_ovr,
                    input  rx_done, rd_data, avail, count, overrun);
    modport slave  (input  rx_rdy, rx_data, rd, clr_ovr,
                    output rx_done, rd_data, avail, count, overrun);
`endif
endinterface

// File: rtl/rs232_rx_fifo.sv
// First-word-fall-through byte FIFO; caller guarantees push only when not full or popping.
module rs232_rx_fifo import rs232_pkg::*; #(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] head,
    output logic [AW:0]       count,
    output logic [AW:0]       count_nxt,
    output logic              full,
    output logic              empty
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Storage is not reset; contents are only visible once count says so.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign head  = mem[rptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
endmodule

// File: rtl/rs232_rx_ctrl.sv
// RS232 receive controller: acks each byte once, buffers into a FIFO, tracks overrun.
// Optional RS232_RX_RTS_EN adds a registered rts flow-control output.
module rs232_rx_ctrl import rs232_pkg::*; #(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AW         = 4,
    parameter int RTS_MARGIN = 4
) (
    input logic             clk,
    input logic             rst,
    rs232_rx_ctrl_if.slave  bus
);
    rx_state_e   state, state_nxt;
    logic        capture, push, pop, full, empty;
    logic [AW:0] count_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: if (bus.rx_rdy) begin
                capture   = 1'b1;
                state_nxt = ACK;
            end
            ACK:  state_nxt = WAIT;
            WAIT: if (!bus.rx_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop  = bus.rd && !empty;
    assign push = capture && (!full || pop);

    rs232_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (bus.rx_data),
        .head      (bus.rd_data),
        .count     (bus.count),
        .count_nxt (count_nxt),
        .full      (full),
        .empty     (empty)
    );

    assign bus.avail = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rx_done <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.rx_done <= (state_nxt == ACK);
            if (capture && !push)
                bus.overrun <= 1'b1;
            else if (bus.clr_ovr)
                bus.overrun <= 1'b0;
        end
    end

`ifdef RS232_RX_RTS_EN
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] MARGIN_C = (AW+1)'(RTS_MARGIN);

    always_ff @(posedge clk) begin
        if (rst) bus.rts <= 1'b1;
        else     bus.rts <= ((DEPTH_C - count_nxt) > MARGIN_C);
    end
`endif
endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Directed bench for rs232_rx_ctrl: vector table for the single-byte handshake, sequences for the rest.
module tb_rs232_rx_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rs232_rx_ctrl_if #(.AW(4)) bus ();

    rs232_rx_ctrl #(.DEPTH(16), .AW(4), .RTS_MARGIN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rx_rdy;
        logic [7:0] rx_data;
        logic       rd;
        logic       clr_ovr;
        logic       e_done;
        logic       e_avail;
        logic [4:0] e_count;
        logic       e_ovr;
        logic       chk_data;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs [6];
    int   passed = 0;
    int   total  = 0;
    int   done_pulses = 0;

    always @(negedge clk) if (!rst && bus.rx_done) done_pulses++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        repeat (hold) tick();
        bus.rx_rdy = 1'b0;
        repeat (2) tick();
    endtask

    task automatic read_byte(input logic [7:0] exp, input string name);
        check(name, int'(bus.rd_data), int'(exp));
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    initial begin
        int snap;
        bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.rd = 1'b0; bus.clr_ovr = 1'b0;

        //            rdy data   rd clr  done avl cnt ovr chk data
        vecs[0] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 8'h5A};
        vecs[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h5A};
        vecs[2] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h5A};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 8'h5A};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};

        repeat (2) tick();
        check("reset_done",  int'(bus.rx_done), 0);
        check("reset_avail", int'(bus.avail),   0);
        check("reset_count", int'(bus.count),   0);
        check("reset_ovr",   int'(bus.overrun), 0);
`ifdef RS232_RX_RTS_EN
        check("reset_rts",   int'(bus.rts),     1);
`endif
        rst = 1'b0;

        // Single byte held three cycles, then pop, then a read while empty.
        snap = done_pulses;
        for (int i = 0; i < 6; i++) begin
            bus.rx_rdy = vecs[i].rx_rdy; bus.rx_data = vecs[i].rx_data;
            bus.rd = vecs[i].rd; bus.clr_ovr = vecs[i].clr_ovr;
            tick();
            check($sformatf("v%0d_done", i),  int'(bus.rx_done), int'(vecs[i].e_done));
            check($sformatf("v%0d_avail", i), int'(bus.avail),   int'(vecs[i].e_avail));
            check($sformatf("v%0d_count", i), int'(bus.count),   int'(vecs[i].e_count));
            check($sformatf("v%0d_ovr", i),   int'(bus.overrun), int'(vecs[i].e_ovr));
            if (vecs[i].chk_data)
                check($sformatf("v%0d_data", i), int'(bus.rd_data), int'(vecs[i].e_data));
        end
        bus.rd = 1'b0;
        check("single_pulses", done_pulses - snap, 1);

        // Burst of 17 into a 16-deep FIFO: last byte dropped.
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1);
        check("burst_count", int'(bus.count),   16);
        check("burst_ovr",   int'(bus.overrun), 1);
        for (int i = 0; i < 16; i++) read_byte(8'(i), $sformatf("burst_rd%0d", i));
        check("burst_empty", int'(bus.avail), 0);
        check("burst_ovr_held", int'(bus.overrun), 1);

        bus.clr_ovr = 1'b1; tick(); bus.clr_ovr = 1'b0;
        check("clr_ovr", int'(bus.overrun), 0);

        // Full FIFO with a simultaneous pop accepts the incoming byte.
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1);
        check("full_count", int'(bus.count), 16);
        bus.rx_rdy = 1'b1; bus.rx_data = 8'hA5; bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0; bus.rx_rdy = 1'b0;
        check("pp_count", int'(bus.count),   16);
        check("pp_ovr",   int'(bus.overrun), 0);
        check("pp_head",  int'(bus.rd_data), 8'h21);
        repeat (2) tick();
        for (int i = 1; i < 16; i++) read_byte(8'(8'h20 + i), $sformatf("pp_rd%0d", i));
        read_byte(8'hA5, "pp_last");
        check("pp_empty", int'(bus.count), 0);

        // Drop and clear in the same cycle: set wins.
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1);
        bus.rx_rdy = 1'b1; bus.rx_data = 8'hEE; bus.clr_ovr = 1'b1;
        tick();
        check("race_ovr", int'(bus.overrun), 1);
        bus.rx_rdy = 1'b0;
        tick();
        bus.clr_ovr = 1'b0;
        check("race_clr", int'(bus.overrun), 0);
        check("race_count", int'(bus.count), 16);
        tick();
        for (int i = 0; i < 16; i++) read_byte(8'(8'h40 + i), $sformatf("race_rd%0d", i));

        // rx_rdy held 20 cycles: one push, one ack.
        snap = done_pulses;
        send_byte(8'h77, 20);
        check("long_pulses", done_pulses - snap, 1);
        check("long_count",  int'(bus.count),   1);
        check("long_data",   int'(bus.rd_data), 8'h77);

        // Reset while in ACK with five bytes held.
        for (int i = 0; i < 3; i++) send_byte(8'(8'h80 + i), 1);
        bus.rx_rdy = 1'b1; bus.rx_data = 8'h99;
        tick();
        check("mid_done",  int'(bus.rx_done), 1);
        check("mid_count", int'(bus.count),   5);
        rst = 1'b1;
        tick();
        check("rst_done",  int'(bus.rx_done), 0);
        check("rst_count", int'(bus.count),   0);
        check("rst_avail", int'(bus.avail),   0);
        rst = 1'b0;
        tick();
        check("rel_done",  int'(bus.rx_done), 1);
        check("rel_count", int'(bus.count),   1);
        check("rel_data",  int'(bus.rd_data), 8'h99);
        bus.rx_rdy = 1'b0;
        repeat (2) tick();

`ifdef RS232_RX_RTS_EN
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 11; i++) send_byte(8'(i), 1);
        check("rts_at11", int'(bus.rts), 1);
        send_byte(8'h0B, 1);
        check("rts_at12", int'(bus.rts), 0);
        read_byte(8'h00, "rts_rd");
        check("rts_after_rd", int'(bus.rts), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
